// File: rtl/defl_port_alloc.sv
// Port allocator for a bufferless deflection router: ranks the four incoming
// flits (golden, age, round-robin) and places each on a distinct output or eject.
module defl_port_alloc #(
   parameter int unsigned MY_X  = 1,
   parameter int unsigned MY_Y  = 1,
   parameter int unsigned EPOCH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] in_n,
   input  logic [10:0] in_s,
   input  logic [10:0] in_e,
   input  logic [10:0] in_w,
   output logic [10:0] out_n,
   output logic [10:0] out_s,
   output logic [10:0] out_e,
   output logic [10:0] out_w,
   output logic [10:0] eject,
   output logic [2:0]  golden_tag,
   output logic [15:0] defl_cnt
);

   localparam int unsigned NIN = 4;
   localparam int unsigned NPORT = 5;
   localparam int unsigned EW = (EPOCH > 1) ? $clog2(EPOCH) : 1;
   localparam logic [EW-1:0] EP_LAST = EW'(EPOCH - 1);
   localparam logic [1:0] MX = 2'(MY_X);
   localparam logic [1:0] MY = 2'(MY_Y);

   // Port indices; eject sits after the four link ports.
   localparam logic [2:0] P_N  = 3'd0;
   localparam logic [2:0] P_S  = 3'd1;
   localparam logic [2:0] P_E  = 3'd2;
   localparam logic [2:0] P_W  = 3'd3;
   localparam logic [2:0] P_EJ = 3'd4;

   typedef struct packed {
      logic       valid;
      logic [1:0] dst_x;
      logic [1:0] dst_y;
      logic [2:0] age;
      logic [2:0] tag;
   } flit_t;

   flit_t         fin    [NIN];
   logic [2:0]    want   [NIN];
   logic [5:0]    key    [NIN];
   logic [2:0]    pos    [NIN];
   logic [NIN-1:0] golden;
   logic [NIN-1:0] vin;

   flit_t          slot  [NPORT];
   logic [NPORT-1:0] busy;
   logic [NIN-1:0] defl;
   logic [1:0]     lf;
   flit_t          bump;
   logic [2:0]     ndefl;
   logic [16:0]    cnt_sum;

   logic [1:0]     rr_ptr;
   logic [EW-1:0]  ep_cnt;

   assign fin[0] = in_n;
   assign fin[1] = in_s;
   assign fin[2] = in_e;
   assign fin[3] = in_w;

   assign vin = {fin[3].valid, fin[2].valid, fin[1].valid, fin[0].valid};

   // XY productive port plus a priority key: golden, age, then rr distance (smaller wins).
   always_comb begin
      for (int i = 0; i < NIN; i++) begin
         if (fin[i].dst_x > MX)      want[i] = P_E;
         else if (fin[i].dst_x < MX) want[i] = P_W;
         else if (fin[i].dst_y > MY) want[i] = P_N;
         else if (fin[i].dst_y < MY) want[i] = P_S;
         else                        want[i] = P_EJ;
         golden[i] = fin[i].valid && (fin[i].tag == golden_tag);
         key[i]    = {golden[i], fin[i].age, ~(2'(i) - rr_ptr)};
      end
   end

   // Rank position = number of valid flits with a strictly larger key; keys are unique.
   always_comb begin
      for (int i = 0; i < NIN; i++) begin
         pos[i] = 3'd0;
         for (int j = 0; j < NIN; j++) begin
            if (j != i && fin[j].valid && (key[j] > key[i]))
               pos[i] = pos[i] + 3'd1;
         end
      end
   end

   // Sequential allocation in rank order; losers take the lowest free link port.
   always_comb begin
      busy = '0;
      defl = '0;
      lf   = 2'd0;
      bump = '0;
      for (int p = 0; p < NPORT; p++) slot[p] = '0;
      for (int r = 0; r < NIN; r++) begin
         for (int i = 0; i < NIN; i++) begin
            if (fin[i].valid && (pos[i] == 3'(r))) begin
               if (!busy[want[i]]) begin
                  busy[want[i]] = 1'b1;
                  slot[want[i]] = fin[i];
               end else begin
                  lf = 2'd0;
                  for (int p = NIN - 1; p >= 0; p--) begin
                     if (!busy[p]) lf = 2'(p);
                  end
                  bump = fin[i];
                  if (bump.age != 3'd7) bump.age = bump.age + 3'd1;
                  busy[lf] = 1'b1;
                  slot[lf] = bump;
                  defl[i]  = 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      ndefl = 3'd0;
      for (int i = 0; i < NIN; i++) ndefl = ndefl + 3'(defl[i]);
      cnt_sum = {1'b0, defl_cnt} + 17'(ndefl);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_n      <= '0;
         out_s      <= '0;
         out_e      <= '0;
         out_w      <= '0;
         eject      <= '0;
         golden_tag <= '0;
         defl_cnt   <= '0;
         rr_ptr     <= '0;
         ep_cnt     <= '0;
      end else begin
         out_n <= slot[P_N];
         out_s <= slot[P_S];
         out_e <= slot[P_E];
         out_w <= slot[P_W];
         eject <= slot[P_EJ];
         defl_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
         if (|vin) rr_ptr <= rr_ptr + 2'd1;
         // Tag advances on epoch wrap; this cycle's allocation already used the old tag.
         if (ep_cnt == EP_LAST) begin
            ep_cnt     <= '0;
            golden_tag <= golden_tag + 3'd1;
         end else begin
            ep_cnt <= ep_cnt + EW'(1);
         end
      end
   end

endmodule

// File: doc/defl_port_alloc.md
# defl_port_alloc

Port allocator for the MinBD bufferless deflection router. It takes the four flits arriving on N/S/E/W in one cycle and assigns each to a distinct output port, or to the single ejection port. Assignment uses XY routing with golden-flit, then age, then round-robin priority. Losers are deflected with their age incremented. It sits between the input latches and the output link registers of the router pipeline.

## Interface
- MY_X, default 1: this router's X coordinate (0..3).
- MY_Y, default 1: this router's Y coordinate (0..3).
- EPOCH, default 16: cycles per golden-tag epoch (≥2).

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_n, in_s, in_e, in_w  in  11  incoming flits
- out_n, out_s, out_e, out_w  out  11  registered outgoing flits
- eject  out  11  registered ejected flit
- golden_tag  out  3  current golden tag
- defl_cnt  out  16  saturating count of deflections

## Operation
- Flit format:
  - [10] valid
  - [9:8] dst_x
  - [7:6] dst_y
  - [5:3] age
  - [2:0] tag
- Invalid flits (bit10=0) are ignored.
- Productive port, evaluated in order:
  - dst_x>MY_X → E; dst_x<MY_X → W.
  - else dst_y>MY_Y → N; dst_y<MY_Y → S.
  - else "arrived" → wants eject.
- Golden flit: valid and tag==golden_tag.
- Rank of valid flits, highest first:
  - golden before non-golden;
  - then higher age;
  - then round-robin: input index order N=0,S=1,E=2,W=3, starting at rr_ptr and wrapping.
- Allocation is sequential in rank order, within the same cycle:
  - Routed flit: takes its productive port if free. Otherwise it takes the lowest-index free port (N,S,E,W) and is deflected.
  - Arrived flit: takes eject if free. Otherwise it is deflected to the lowest-index free port.
- Deflected flit: age+1, saturating at 7. A non-deflected flit is forwarded unchanged. Eject carries the flit unchanged.
- Four inputs and four outputs guarantee every valid flit is placed; no flit is ever dropped.
- Unassigned outputs and eject are driven 11'd0.
- defl_cnt += number of deflections this cycle (0..4), saturating at 16'hFFFF.
- rr_ptr (2-bit, internal) advances by 1 mod 4 on any cycle with at least one valid input. It is held otherwise.
- Epoch counter (internal) counts 0..EPOCH-1. On wrap from EPOCH-1 to 0, golden_tag increments mod 8.

## Timing
- Latency 1 cycle: inputs sampled at edge k appear on out_*/eject after edge k.
- golden_tag and rr_ptr used at edge k are the values registered before edge k. An update takes effect for the next cycle's allocation.
- After rst=1 at an edge, all of the following are 0: out_*, eject, golden_tag, defl_cnt, epoch counter, rr_ptr. Inputs sampled during reset are discarded.
- Reset mid-operation: in-flight registered flits are cleared at that edge. The epoch restarts, so golden_tag=1 first appears EPOCH cycles after rst deasserts.
- No handshake; downstream is always ready (bufferless).
- Simultaneous events:
  - Epoch wrap and allocation in the same cycle: allocation uses the old tag.
  - defl_cnt saturation and new deflections in the same cycle: the count stays at FFFF.

## Test plan
- Single routed flit, MY=(1,1): in_n={1,2'd2,2'd1,3'd0,3'd5} → next cycle out_e = same flit; other outputs 0; defl_cnt 0.
- Contention, both routed E:
  - Stimulus: in_n age 3 tag 5, in_s age 1 tag 6, reset just released (golden_tag=0).
  - Response: out_e = in_n unchanged; out_n = in_s with age 2; defl_cnt=1.
- Golden beats age, both routed E, golden_tag=0:
  - Stimulus: in_w age 0 tag 0; in_n age 7 tag 3.
  - Response: out_e = in_w; in_n deflected to out_n with age staying 7 (saturated); defl_cnt=1.
- Two arrived flits at (1,1):
  - Stimulus: in_e age 4, in_s age 2.
  - Response: eject = in_e unchanged; in_s deflected to out_n with age 3.
- Epoch and tie-break:
  - Golden tag: with EPOCH=16, golden_tag reads 1 after 16 cycles and 0 again after 128.
  - Round-robin: equal-age, non-golden flits on all four inputs, all routed E, starting from rr_ptr=0 → N wins E; with rr_ptr=1, S wins.
- Reset mid-traffic: assert rst for one edge while four flits are in flight → all outputs, defl_cnt and golden_tag read 0 the following cycle.
